// File: rtl/spi_reg_bank_pkg.sv
// Register map constants and address decode helpers shared by the SPI register bank.
package spi_regmap_pkg;

    localparam int ADDR_W = 7;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t        FLAGS_ADDR    = 7'h7C;
    localparam addr_t        IRQ_MASK_ADDR = 7'h7D;
    localparam addr_t        ERR_ADDR      = 7'h7E;
    localparam addr_t        ID_ADDR       = 7'h7F;
    localparam addr_t        STAT_BASE     = 7'h40;
    localparam logic [23:0]  ID_VALUE      = 24'h564E41;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_STAT,
        REG_FLAGS,
        REG_MASK,
        REG_ERR,
        REG_ID,
        REG_NONE
    } reg_kind_e;

    function automatic logic is_ctrl(input addr_t addr, input int num_ctrl);
        return int'(addr) < num_ctrl;
    endfunction

    function automatic logic is_stat(input addr_t addr, input addr_t stat_base, input int num_stat);
        return (int'(addr) >= int'(stat_base)) && (int'(addr) < int'(stat_base) + num_stat);
    endfunction

    function automatic logic is_mapped(input addr_t addr, input int num_ctrl,
                                       input addr_t stat_base, input int num_stat);
        return is_ctrl(addr, num_ctrl) || is_stat(addr, stat_base, num_stat) ||
               (addr == FLAGS_ADDR) || (addr == IRQ_MASK_ADDR) ||
               (addr == ERR_ADDR) || (addr == ID_ADDR);
    endfunction

    // Control registers win over any overlapping window if parameters are set oddly.
    function automatic reg_kind_e decode(input addr_t addr, input int num_ctrl,
                                         input addr_t stat_base, input int num_stat);
        if (is_ctrl(addr, num_ctrl))                 return REG_CTRL;
        if (is_stat(addr, stat_base, num_stat))      return REG_STAT;
        if (addr == FLAGS_ADDR)                      return REG_FLAGS;
        if (addr == IRQ_MASK_ADDR)                   return REG_MASK;
        if (addr == ERR_ADDR)                        return REG_ERR;
        if (addr == ID_ADDR)                         return REG_ID;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// Decoded SPI slave strobes towards the register bank, and read data back to the slave.
interface spi_reg_bank_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 24
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_ready;
    logic                  rw;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] data_in;

    modport master (output addr, addr_ready, rw, data, data_ready, input data_in);
    modport slave  (input addr, addr_ready, rw, data, data_ready, output data_in);
endinterface

// File: rtl/spi_w1c_flags.sv
// Sticky event flags with write-one-to-clear, an interrupt mask and a registered irq.
module spi_w1c_flags #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clr,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_d,
    output logic [WIDTH-1:0] flags,
    output logic [WIDTH-1:0] mask,
    output logic             irq
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
            mask  <= '0;
            irq   <= 1'b0;
        end else begin
            // A new event in the same cycle as its clear must not be lost.
            flags <= (flags & ~clr) | set;
            if (mask_we) begin
                mask <= mask_d;
            end
            irq <= |(flags & mask);
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank behind the soft SPI slave: control registers, status snapshots,
// W1C event flags with irq, an error counter and a constant ID word.
module spi_reg_bank
    import spi_regmap_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 24,
    parameter int                    NUM_CTRL   = 16,
    parameter int                    NUM_STAT   = 8,
    parameter logic [ADDR_WIDTH-1:0] STAT_BASE  = spi_regmap_pkg::STAT_BASE,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = spi_regmap_pkg::ID_VALUE
) (
    input  logic                           clk,
    input  logic                           rst,
    spi_reg_bank_if.slave                  spi,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_regs,
    output logic [NUM_CTRL-1:0]            ctrl_wr,
    input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_in,
    input  logic [DATA_WIDTH-1:0]          flag_set,
    output logic                           irq,
    output logic [7:0]                     err_count
);

    logic                  addr_ready_q;
    logic                  data_ready_q;
    logic                  addr_rise;
    logic                  addr_fall;
    logic                  data_rise;

    logic                  frame_active;
    logic                  frame_rw;
    logic [ADDR_WIDTH-1:0] frame_addr;

    logic [DATA_WIDTH-1:0] ctrl_q [NUM_CTRL];
    logic [DATA_WIDTH-1:0] flags;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] flag_clr;
    logic                  mask_we;

    reg_kind_e             rd_kind;
    reg_kind_e             wr_kind;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_fire;
    logic                  err_inc;
    logic                  err_clr;

    assign addr_rise = spi.addr_ready & ~addr_ready_q;
    assign addr_fall = ~spi.addr_ready & addr_ready_q;
    assign data_rise = spi.data_ready & ~data_ready_q;

    assign rd_kind = decode(addr_t'(spi.addr), NUM_CTRL, addr_t'(STAT_BASE), NUM_STAT);
    assign wr_kind = decode(addr_t'(frame_addr), NUM_CTRL, addr_t'(STAT_BASE), NUM_STAT);
    assign wr_fire = data_rise & frame_active & ~frame_rw;

    // Edge history resets high so levels still asserted at reset release are not taken as rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_ready_q <= 1'b1;
            data_ready_q <= 1'b1;
            frame_active <= 1'b0;
            frame_rw     <= 1'b0;
            frame_addr   <= '0;
        end else begin
            addr_ready_q <= spi.addr_ready;
            data_ready_q <= spi.data_ready;
            if (addr_rise) begin
                frame_active <= 1'b1;
                frame_rw     <= spi.rw;
                frame_addr   <= spi.addr;
            end else if (addr_fall || data_rise) begin
                frame_active <= 1'b0;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_data = '0;
        unique case (rd_kind)
            REG_CTRL: begin
                for (int i = 0; i < NUM_CTRL; i++) begin
                    if (int'(spi.addr) == i) rd_data = ctrl_q[i];
                end
            end
            REG_STAT: begin
                for (int i = 0; i < NUM_STAT; i++) begin
                    if (int'(spi.addr) == int'(STAT_BASE) + i) rd_data = stat_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            REG_FLAGS: rd_data = flags;
            REG_MASK:  rd_data = irq_mask;
            REG_ERR:   rd_data = DATA_WIDTH'(err_count);
            REG_ID:    rd_data = ID_VALUE;
            default:   rd_data = '0;
        endcase
    end

    always_comb begin
        flag_clr = '0;
        mask_we  = 1'b0;
        err_inc  = 1'b0;
        err_clr  = 1'b0;
        if (addr_rise && spi.rw && rd_kind == REG_NONE) begin
            err_inc = 1'b1;
        end
        if (wr_fire) begin
            unique case (wr_kind)
                REG_FLAGS: flag_clr = spi.data;
                REG_MASK:  mask_we  = 1'b1;
                REG_ERR:   err_clr  = 1'b1;
                REG_STAT, REG_ID, REG_NONE: err_inc = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spi.data_in <= '0;
        end else if (addr_rise) begin
            spi.data_in <= rd_data;
        end
    end

    // NOTE: the control array is real flops with a defined reset value, so it is reset like any register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
            ctrl_wr <= '0;
        end else begin
            ctrl_wr <= '0;
            if (wr_fire && wr_kind == REG_CTRL) begin
                for (int i = 0; i < NUM_CTRL; i++) begin
                    if (int'(frame_addr) == i) begin
                        ctrl_q[i]  <= spi.data;
                        ctrl_wr[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (err_inc && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_flat
        assign ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
    end

    spi_w1c_flags #(.WIDTH(DATA_WIDTH)) u_flags (
        .clk     (clk),
        .rst     (rst),
        .set     (flag_set),
        .clr     (flag_clr),
        .mask_we (mask_we),
        .mask_d  (spi.data),
        .flags   (flags),
        .mask    (irq_mask),
        .irq     (irq)
    );

endmodule
